// File: rtl/load_unit.sv
// load_unit: RV32I load engine (LB/LH/LW/LBU/LHU).
// Takes one load at a time from execute, performs a single-beat word read on
// the data bus, aligns/extends the returned data and writes it through
// register-file write port 2. Exposes the in-flight destination so decode can
// stall on RAW hazards, and drops its own writeback when a younger instruction
// has already written the same register (WAW).
module load_unit #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [4:0]  load_rd,
    input  logic [31:0] load_address,
    input  logic [2:0]  load_funct3,
    output logic        mem_request,
    output logic [31:0] mem_address,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  execute_write_address,
    output logic [4:0]  write_address,
    output logic [31:0] write_value,
    output logic        busy,
    output logic [4:0]  pending_rd,
    output logic        load_error
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] REQUEST   = 2'd1;
    localparam logic [1:0] WRITEBACK = 2'd2;
    localparam logic [1:0] FAULT     = 2'd3;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]  state;
    logic [1:0]  state_next;
    logic [4:0]  rd_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] data_q;
    logic        cancel_q;
    logic [31:0] timeout_q;

    logic        accept;
    logic        request_legal;
    logic        timeout_hit;
    logic        waw_hit;

    // A load is legal when its encoding exists and its address is naturally
    // aligned for its width; anything else is reported as a fault.
    function automatic logic is_legal(input logic [2:0] f3, input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = 1'b1;
            F3_LH, F3_LHU: ok = (off[0] == 1'b0);
            F3_LW:         ok = (off == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Pick the addressed byte/halfword out of the bus word and extend it.
    function automatic logic [31:0] extract(input logic [2:0]  f3,
                                            input logic [1:0]  off,
                                            input logic [31:0] word);
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        logic [31:0] result;
        case (off)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
        sel_half = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_LB:   result = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  result = {24'd0, sel_byte};
            F3_LH:   result = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  result = {16'd0, sel_half};
            default: result = word;
        endcase
        return result;
    endfunction

    assign accept        = load_valid && (state == IDLE);
    assign request_legal = is_legal(load_funct3, load_address[1:0]);
    assign timeout_hit   = (ACK_TIMEOUT != 0) && (timeout_q == (ACK_TIMEOUT - 32'd1));
    assign waw_hit       = (state == REQUEST) && (rd_q != 5'd0) &&
                           (execute_write_address == rd_q);

    // Next-state selection for the load sequence.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = request_legal ? REQUEST : FAULT;
                end
            end
            REQUEST: begin
                if (mem_ack) begin
                    state_next = WRITEBACK;
                end else if (timeout_hit) begin
                    state_next = FAULT;
                end
            end
            WRITEBACK: state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // State register; reset abandons any load in flight.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the request fields on accept and the bus word on acknowledge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_q     <= 5'd0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            data_q   <= 32'd0;
        end else begin
            if (accept) begin
                rd_q     <= load_rd;
                addr_q   <= load_address;
                funct3_q <= load_funct3;
            end
            if ((state == REQUEST) && mem_ack) begin
                data_q <= mem_rdata;
            end
        end
    end

    // WAW cancel: a port-1 write to our rd while we wait means a younger
    // instruction already owns that register. The accept-cycle write is
    // ignored because it comes from an older instruction.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cancel_q <= 1'b0;
        end else if (accept) begin
            cancel_q <= 1'b0;
        end else if (waw_hit) begin
            cancel_q <= 1'b1;
        end
    end

    // Count REQUEST cycles without an acknowledge for the bus timeout.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            timeout_q <= 32'd0;
        end else if (accept) begin
            timeout_q <= 32'd0;
        end else if ((state == REQUEST) && !mem_ack) begin
            timeout_q <= timeout_q + 32'd1;
        end
    end

    // Outputs are decoded from the current state only.
    always_comb begin
        load_ready    = (state == IDLE);
        mem_request   = (state == REQUEST);
        mem_address   = 32'd0;
        write_address = 5'd0;
        write_value   = 32'd0;
        busy          = (state == REQUEST) || (state == WRITEBACK);
        pending_rd    = 5'd0;
        load_error    = (state == FAULT);
        if (state == REQUEST) begin
            mem_address = {addr_q[31:2], 2'b00};
        end
        if (state == WRITEBACK) begin
            write_address = cancel_q ? 5'd0 : rd_q;
            write_value   = extract(funct3_q, addr_q[1:0], data_q);
        end
        if (busy) begin
            pending_rd = rd_q;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed self-checking bench for load_unit.
// Main instance uses the default timeout; a second instance with a short
// timeout and no acknowledge exercises the bus-fault path.
module tb_load_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        load_valid;
    logic [4:0]  load_rd;
    logic [31:0] load_address;
    logic [2:0]  load_funct3;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  execute_write_address;

    logic        load_ready;
    logic        mem_request;
    logic [31:0] mem_address;
    logic [4:0]  write_address;
    logic [31:0] write_value;
    logic        busy;
    logic [4:0]  pending_rd;
    logic        load_error;

    logic        load_valid_to;
    logic        mem_ack_to;
    logic        load_ready_to;
    logic        mem_request_to;
    logic [31:0] mem_address_to;
    logic [4:0]  write_address_to;
    logic [31:0] write_value_to;
    logic        busy_to;
    logic [4:0]  pending_rd_to;
    logic        load_error_to;

    int checks = 0;
    int passes = 0;

    load_unit dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .load_valid            (load_valid),
        .load_ready            (load_ready),
        .load_rd               (load_rd),
        .load_address          (load_address),
        .load_funct3           (load_funct3),
        .mem_request           (mem_request),
        .mem_address           (mem_address),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata),
        .execute_write_address (execute_write_address),
        .write_address         (write_address),
        .write_value           (write_value),
        .busy                  (busy),
        .pending_rd            (pending_rd),
        .load_error            (load_error)
    );

    load_unit #(.ACK_TIMEOUT(3)) dut_to (
        .clock                 (clock),
        .reset_n               (reset_n),
        .load_valid            (load_valid_to),
        .load_ready            (load_ready_to),
        .load_rd               (load_rd),
        .load_address          (load_address),
        .load_funct3           (load_funct3),
        .mem_request           (mem_request_to),
        .mem_address           (mem_address_to),
        .mem_ack               (mem_ack_to),
        .mem_rdata             (mem_rdata),
        .execute_write_address (execute_write_address),
        .write_address         (write_address_to),
        .write_value           (write_value_to),
        .busy                  (busy_to),
        .pending_rd            (pending_rd_to),
        .load_error            (load_error_to)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clock = ~clock;

    // Advance one cycle and settle just past the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present a load for exactly one accepting edge.
    task automatic issue(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3);
        load_valid   = 1'b1;
        load_rd      = rd;
        load_address = addr;
        load_funct3  = f3;
        step();
        load_valid   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (load_ready !== 1'b1) $display("[TB] FAIL reset_load_ready got %b want 1", load_ready); else passes++;
        checks++; if (mem_request !== 1'b0) $display("[TB] FAIL reset_mem_request got %b want 0", mem_request); else passes++;
        checks++; if (mem_address !== 32'h0) $display("[TB] FAIL reset_mem_address got %h want 0", mem_address); else passes++;
        checks++; if (write_address !== 5'd0) $display("[TB] FAIL reset_write_address got %0d want 0", write_address); else passes++;
        checks++; if (write_value !== 32'h0) $display("[TB] FAIL reset_write_value got %h want 0", write_value); else passes++;
        checks++; if (busy !== 1'b0 || pending_rd !== 5'd0) $display("[TB] FAIL reset_busy got %b/%0d want 0/0", busy, pending_rd); else passes++;
        checks++; if (load_error !== 1'b0) $display("[TB] FAIL reset_load_error got %b want 0", load_error); else passes++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        issue(5'd5, 32'h0000_1000, 3'b010);
        checks++; if (mem_request !== 1'b1 || mem_address !== 32'h0000_1000) $display("[TB] FAIL lw_request got %b/%h want 1/00001000", mem_request, mem_address); else passes++;
        checks++; if (load_ready !== 1'b0 || busy !== 1'b1 || pending_rd !== 5'd5) $display("[TB] FAIL lw_busy got ready=%b busy=%b rd=%0d want 0/1/5", load_ready, busy, pending_rd); else passes++;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        checks++; if (write_address !== 5'd5 || write_value !== 32'hDEAD_BEEF) $display("[TB] FAIL lw_write got %0d/%h want 5/deadbeef", write_address, write_value); else passes++;
        checks++; if (mem_request !== 1'b0 || load_ready !== 1'b0) $display("[TB] FAIL lw_wb_state got req=%b ready=%b want 0/0", mem_request, load_ready); else passes++;
        step();
        checks++; if (load_ready !== 1'b1 || write_address !== 5'd0 || busy !== 1'b0) $display("[TB] FAIL lw_idle got ready=%b wa=%0d busy=%b want 1/0/0", load_ready, write_address, busy); else passes++;
    endtask

    task automatic test_extract();
        // Back-to-back loads: each starts the cycle load_ready returns.
        logic [2:0]  f3s  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b000};
        logic [31:0] adrs [5] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000, 32'h1001};
        logic [31:0] exps [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_1234, 32'h0000_0012};
        for (int i = 0; i < 5; i++) begin
            issue(5'd10 + 5'(i), adrs[i], f3s[i]);
            checks++; if (mem_address !== 32'h0000_1000) $display("[TB] FAIL ext%0d_mem_address got %h want 00001000", i, mem_address); else passes++;
            mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
            step();
            mem_ack = 1'b0;
            checks++; if (write_address !== 5'd10 + 5'(i) || write_value !== exps[i]) $display("[TB] FAIL ext%0d_write got %0d/%h want %0d/%h", i, write_address, write_value, 10 + i, exps[i]); else passes++;
            step();
        end
    endtask

    task automatic test_fault();
        logic [2:0]  f3s  [3] = '{3'b001, 3'b011, 3'b010};
        logic [31:0] adrs [3] = '{32'h1001, 32'h1000, 32'h1002};
        for (int i = 0; i < 3; i++) begin
            issue(5'd4, adrs[i], f3s[i]);
            checks++; if (load_error !== 1'b1 || mem_request !== 1'b0 || write_address !== 5'd0) $display("[TB] FAIL fault%0d_pulse got err=%b req=%b wa=%0d want 1/0/0", i, load_error, mem_request, write_address); else passes++;
            checks++; if (busy !== 1'b0 || load_ready !== 1'b0) $display("[TB] FAIL fault%0d_state got busy=%b ready=%b want 0/0", i, busy, load_ready); else passes++;
            step();
            checks++; if (load_error !== 1'b0 || load_ready !== 1'b1 || mem_request !== 1'b0) $display("[TB] FAIL fault%0d_end got err=%b ready=%b req=%b want 0/1/0", i, load_error, load_ready, mem_request); else passes++;
        end
    endtask

    task automatic test_cancel();
        // Younger write to rd=7 while waiting: writeback is suppressed.
        execute_write_address = 5'd7;
        issue(5'd7, 32'h0000_2000, 3'b010);
        execute_write_address = 5'd0;
        for (int c = 1; c <= 4; c++) begin
            if (c == 2) execute_write_address = 5'd7; else execute_write_address = 5'd0;
            if (c == 4) begin mem_ack = 1'b1; mem_rdata = 32'h1234_5678; end
            checks++; if (busy !== 1'b1 || pending_rd !== 5'd7 || mem_request !== 1'b1) $display("[TB] FAIL cancel_c%0d got busy=%b rd=%0d req=%b want 1/7/1", c, busy, pending_rd, mem_request); else passes++;
            step();
        end
        mem_ack = 1'b0; execute_write_address = 5'd0;
        checks++; if (write_address !== 5'd0 || write_value !== 32'h1234_5678) $display("[TB] FAIL cancel_wb got %0d/%h want 0/12345678", write_address, write_value); else passes++;
        checks++; if (busy !== 1'b1 || pending_rd !== 5'd7) $display("[TB] FAIL cancel_wb_busy got %b/%0d want 1/7", busy, pending_rd); else passes++;
        step();
        // Same-rd writes in the accept cycle and the writeback cycle do not cancel.
        execute_write_address = 5'd7;
        issue(5'd7, 32'h0000_2004, 3'b010);
        execute_write_address = 5'd0;
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        execute_write_address = 5'd7;
        checks++; if (write_address !== 5'd7 || write_value !== 32'h0BAD_F00D) $display("[TB] FAIL nocancel_wb got %0d/%h want 7/0badf00d", write_address, write_value); else passes++;
        step();
        execute_write_address = 5'd0;
        // rd=0 still does the bus access but never writes.
        issue(5'd0, 32'h0000_3008, 3'b010);
        checks++; if (mem_request !== 1'b1 || mem_address !== 32'h0000_3008 || pending_rd !== 5'd0) $display("[TB] FAIL rd0_req got %b/%h/%0d want 1/00003008/0", mem_request, mem_address, pending_rd); else passes++;
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        step();
        mem_ack = 1'b0;
        checks++; if (write_address !== 5'd0 || busy !== 1'b1) $display("[TB] FAIL rd0_wb got wa=%0d busy=%b want 0/1", write_address, busy); else passes++;
        step();
    endtask

    task automatic test_timeout();
        load_valid_to = 1'b1; load_rd = 5'd3; load_address = 32'h0000_3000; load_funct3 = 3'b010;
        step();
        load_valid_to = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            checks++; if (mem_request_to !== 1'b1 || load_error_to !== 1'b0 || mem_address_to !== 32'h0000_3000) $display("[TB] FAIL timeout_req%0d got req=%b err=%b addr=%h want 1/0/00003000", c, mem_request_to, load_error_to, mem_address_to); else passes++;
            step();
        end
        checks++; if (load_error_to !== 1'b1 || mem_request_to !== 1'b0 || write_address_to !== 5'd0) $display("[TB] FAIL timeout_fault got err=%b req=%b wa=%0d want 1/0/0", load_error_to, mem_request_to, write_address_to); else passes++;
        step();
        checks++; if (load_ready_to !== 1'b1 || load_error_to !== 1'b0 || busy_to !== 1'b0) $display("[TB] FAIL timeout_idle got ready=%b err=%b busy=%b want 1/0/0", load_ready_to, load_error_to, busy_to); else passes++;
    endtask

    task automatic test_reset_mid();
        issue(5'd9, 32'h0000_4000, 3'b010);
        checks++; if (busy !== 1'b1 || pending_rd !== 5'd9) $display("[TB] FAIL midreset_pre got %b/%0d want 1/9", busy, pending_rd); else passes++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        checks++; if (load_ready !== 1'b1 || mem_request !== 1'b0 || mem_address !== 32'h0 || busy !== 1'b0 || pending_rd !== 5'd0) $display("[TB] FAIL midreset_state got ready=%b req=%b addr=%h busy=%b rd=%0d want 1/0/0/0/0", load_ready, mem_request, mem_address, busy, pending_rd); else passes++;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_CAFE;
        step();
        mem_ack = 1'b0;
        checks++; if (write_address !== 5'd0 || write_value !== 32'h0 || load_ready !== 1'b1 || load_error !== 1'b0) $display("[TB] FAIL midreset_lateack got wa=%0d wv=%h ready=%b err=%b want 0/0/1/0", write_address, write_value, load_ready, load_error); else passes++;
        step();
        checks++; if (write_address !== 5'd0 || busy !== 1'b0) $display("[TB] FAIL midreset_after got wa=%0d busy=%b want 0/0", write_address, busy); else passes++;
    endtask

    // Drive all scenarios in order, then report.
    initial begin
        reset_n = 1'b0;
        load_valid = 1'b0; load_valid_to = 1'b0;
        load_rd = 5'd0; load_address = 32'h0; load_funct3 = 3'd0;
        mem_ack = 1'b0; mem_ack_to = 1'b0; mem_rdata = 32'h0;
        execute_write_address = 5'd0;
        #1;
        test_reset();
        test_lw();
        test_extract();
        test_fault();
        test_cancel();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
- Executes RV32I loads (LB/LH/LW/LBU/LHU) for the CPU.
- Accepts one load at a time from execute and runs a single-beat word read on the data bus.
- Aligns and extends the returned data, then drives write port 2 of the register file.
- Exports a pending-destination scoreboard so decode can stall on RAW hazards, and suppresses its own writeback when a younger instruction has already written the same register (WAW).

Parameters:
- ACK_TIMEOUT, 255: cycles to wait in REQUEST for mem_ack before faulting; 0 disables the timeout.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  synchronous active-low reset.
- load_valid  input  1  execute presents a load.
- load_ready  output  1  unit can accept a load; high only in IDLE.
- load_rd  input  5  destination register.
- load_address  input  32  effective byte address.
- load_funct3  input  3  load width/sign encoding.
- mem_request  output  1  bus read request.
- mem_address  output  32  word-aligned read address.
- mem_ack  input  1  read data valid this cycle.
- mem_rdata  input  32  read data.
- execute_write_address  input  5  register-file write port 1 address this cycle.
- write_address  output  5  to register-file write port 2; 0 means no write.
- write_value  output  32  to register-file write port 2.
- busy  output  1  a load is in flight.
- pending_rd  output  5  destination of the in-flight load; 0 when not busy.
- load_error  output  1  one-cycle fault pulse.

Behaviour:
- States: IDLE, REQUEST, WRITEBACK, FAULT.
- Reset (reset_n=0 at posedge): state=IDLE, cancel flag and timeout counter cleared. Resulting outputs:
  - load_ready=1
  - mem_request=0, mem_address=0
  - write_address=0, write_value=0
  - busy=0, pending_rd=0, load_error=0
- Reset mid-operation aborts the load with no writeback. An mem_ack arriving while in IDLE is ignored.
- Accept: load_valid && load_ready at posedge. The unit latches rd, address, funct3 and clears the cancel flag.
  - Valid and aligned: next state REQUEST.
  - Fault cases go to FAULT: funct3 in {011,110,111}; halfword with address[0]=1; word with address[1:0]!=0.
- REQUEST:
  - mem_request=1 and mem_address={addr[31:2],2'b00}, both held stable until ack.
  - On mem_ack=1: capture mem_rdata, next state WRITEBACK.
  - Timeout counter increments each REQUEST cycle without ack. If ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT, next state is FAULT.
  - Minimum latency: accept at cycle 0, ack at cycle 1, write at cycle 2, load_ready again at cycle 3.
- WRITEBACK (exactly one cycle):
  - write_address = cancel ? 0 : rd.
  - write_value = extracted data; next state IDLE.
  - write_address/write_value are 0 in all other states.
- Extraction uses byte offset o=addr[1:0]:
  - LB sign-extends byte o; LBU zero-extends byte o.
  - LH sign-extends halfword o[1]; LHU zero-extends halfword o[1].
  - LW passes the word through.
- FAULT: load_error=1 for one cycle, no bus request, no write, next state IDLE.
- busy=1 in REQUEST and WRITEBACK. pending_rd=rd when busy, else 0. FAULT is not busy.
- Cancel (WAW): the flag sets when the state is REQUEST and execute_write_address==rd with rd!=0.
  - Not sampled in the accept cycle, since that write belongs to an older instruction.
  - In the WRITEBACK cycle itself, a same-address port-1 write wins inside the register file. The unit still drives rd.
- rd=0: the bus access is still performed; write_address=0 in WRITEBACK.
- Only one load is outstanding; load_valid while not ready is held by execute.

Test Plan:
- LW of 0x1000, rd=5; mem_ack on the first REQUEST cycle with rdata=0xDEADBEEF -> write_address=5, write_value=0xDEADBEEF two cycles after accept; load_ready back one cycle later.
- LB and LBU at 0x1003 with rdata=0x80FF1234 -> mem_address=0x1000; LB writes 0xFFFFFF80, LBU writes 0x00000080. LH at 0x1002 with the same data -> 0xFFFF80FF.
- LH at 0x1001, then funct3=011 -> load_error pulses one cycle each time, mem_request stays 0, write_address stays 0.
- LW to rd=7 with ack delayed 4 cycles; execute_write_address=7 on cycle 2 -> busy=1 and pending_rd=7 throughout; WRITEBACK drives write_address=0.
- ACK_TIMEOUT=3 with mem_ack never asserted -> mem_request high for 3 cycles, then load_error=1, then IDLE.
- reset_n=0 during REQUEST, then a late mem_ack -> next cycle all outputs at reset values; no write occurs.
